// File: rtl/branch_unit.sv
// Branch resolution with a PC-indexed table of 2-bit saturating predictors.
// Optional BRANCH_STATS_EN adds resolved/mispredicted branch counters.
module branch_unit #(
  parameter int         DATA_W   = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic [2:0]        res_op,
  input  logic [DATA_W-1:0] res_rs,
  input  logic [DATA_W-1:0] res_rt,
  input  logic              res_pred,
  output logic              PC_sel,
`ifdef BRANCH_STATS_EN
  output logic [31:0]       br_count,
  output logic [31:0]       mp_count,
`endif
  output logic              mispredict
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       cnt_q [DEPTH];
  logic [1:0]       cnt_d;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cond;
  logic             rs_neg;
  logic             rs_zero;
  logic             upd;
  logic             unused_pc;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign res_idx = res_pc[IDX_W+1:2];
  assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                       res_pc[31:IDX_W+2], res_pc[1:0]};

  assign rs_neg  = res_rs[DATA_W-1];
  assign rs_zero = (res_rs == '0);

  always_comb begin
    cond = 1'b0;
    unique case (res_op)
      3'b000: cond = (res_rs == res_rt);
      3'b001: cond = (res_rs != res_rt);
      3'b010: cond = rs_neg | rs_zero;
      3'b011: cond = ~rs_neg & ~rs_zero;
      3'b100: cond = rs_neg;
      3'b101: cond = ~rs_neg;
      3'b110: cond = 1'b1;
      3'b111: cond = 1'b0;
      default: cond = 1'b0;
    endcase
  end

  assign pred_taken = cnt_q[if_idx][1];
  assign PC_sel     = res_valid & cond;
  assign mispredict = res_valid & (cond ^ res_pred);

  // Unconditional modes (110/111) never train the table.
  assign upd = res_valid & ~(res_op[2] & res_op[1]);

  always_comb begin
    cnt_d = cnt_q[res_idx];
    if (cond) begin
      if (cnt_q[res_idx] != 2'b11) cnt_d = cnt_q[res_idx] + 2'd1;
    end else begin
      if (cnt_q[res_idx] != 2'b00) cnt_d = cnt_q[res_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= INIT_CNT;
    end else if (upd) begin
      cnt_q[res_idx] <= cnt_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_q, br_d;
  logic [31:0] mp_q, mp_d;

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (upd) begin
      br_d = br_q + 32'd1;
      if (mispredict) mp_d = mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign br_count = br_q;
  assign mp_count = mp_q;
`endif

endmodule
